calc_entry_ctrl: RTL and testbench
==================================

Name: calc_entry_ctrl

Overview:
Sequences operand and operator entry for the calculator from four front-panel buttons and the operand switches, then hands the operation to the ALU over a start/done handshake. Each raw button is synchronised, edge-detected and locked out for a fixed hold-off. Same-cycle button events are arbitrated by fixed priority. The block sits between the board I/O and the ALU/display path.

Parameters:
W, 8, operand width in bits (switch width)
LOCKOUT_CYC, 1000000, cycles after an accepted edge during which the same button is ignored (10 ms at 100 MHz); >=1

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
btn_raw  in  4  raw buttons: [0]=enter, [1]=op_next, [2]=op_prev, [3]=clear
sw  in  W  operand value from switches
alu_done  in  1  ALU result valid, single-cycle pulse
alu_result  in  2W  ALU result, valid with alu_done
op_a  out  W  latched operand A
op_b  out  W  latched operand B
op_sel  out  2  operator: 0=ADD, 1=SUB, 2=MUL, 3=DIV
alu_start  out  1  one-cycle request to the ALU
result  out  2W  latched result
result_valid  out  1  high while in S_SHOW
err  out  1  divide-by-zero flag, high while in S_SHOW after a rejected DIV
state_o  out  3  current state encoding, for display

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst, and rst has priority over every other input.
- Reset values: op_a=0, op_b=0, op_sel=0, result=0, alu_start=0, result_valid=0, err=0, state=S_A. All lockout counters and synchroniser flops are cleared.
- Per-button front end:
  - 2-flop synchroniser, then a third flop for rising-edge detect (sync_q & ~prev_q).
  - An edge is accepted only when that button's lockout counter is 0. Acceptance loads the counter with LOCKOUT_CYC; it decrements each cycle down to 0.
  - Latency: raw rise to event pulse is 3 cycles.
  - A level held high produces exactly one event.
- Arbitration: if several accepted events occur in one cycle, the priority is clear > enter > op_next > op_prev. Losers are dropped, not queued, but their lockout still starts.
- FSM (state_o encoding in brackets):
  - S_A [0]: on enter, op_a<=sw, go to S_OP.
  - S_OP [1]: op_next gives op_sel+1 and op_prev gives op_sel-1, both mod 4 (3->0, 0->3). On enter, go to S_B.
  - S_B [2]: on enter, op_b<=sw.
    - If op_sel==DIV and sw==0: result<=0, err<=1, go to S_SHOW; no alu_start is issued.
    - Otherwise assert alu_start for the next cycle and go to S_CALC.
  - S_CALC [3]: alu_start is high for exactly the first cycle of this state. Buttons other than clear are ignored. On alu_done: result<=alu_result, err<=0, go to S_SHOW. alu_done may arrive as early as the cycle after alu_start; there is no timeout.
  - S_SHOW [4]: result_valid=1. On enter, go to S_A; op_a, op_b and op_sel are kept, and result_valid and err drop.
- clear in any state: go to S_A next cycle; op_a, op_b, op_sel, result and err become 0. If clear arrives in S_CALC, a later alu_done is ignored.
- alu_done outside S_CALC is ignored.
- Encodings 5-7 are unreachable; if reached, the next state is S_A.

Decomposition:
- Package calc_pkg holds:
  - typedef enum logic[2:0] state_t {S_A, S_OP, S_B, S_CALC, S_SHOW}
  - typedef enum logic[1:0] op_t {OP_ADD, OP_SUB, OP_MUL, OP_DIV}
  - localparams for the button indices.
- Sub-module btn_lockout: synchroniser, edge detect and lockout counter, parameter LOCKOUT_CYC. It is instantiated 4 times; arbitration and FSM stay in the top.

Test Plan (W=8, LOCKOUT_CYC=4):
- Reset, then full ADD: sw=5, enter; op_next x0; enter; sw=7, enter -> alu_start is one pulse with op_a=5, op_b=7, op_sel=0. Bench returns alu_done with alu_result=12 -> result=12, result_valid=1, state_o=4.
- Lockout: hold enter high for 10 cycles -> one event only. Two enter rises 2 cycles apart -> second ignored. Rises 6 cycles apart -> both accepted.
- Operator wrap: in S_OP, op_prev from op_sel=0 -> 3. Then op_next -> 0.
- Divide by zero: op_sel=3, op_a=9, sw=0, enter in S_B -> no alu_start, err=1, result=0, S_SHOW. A following enter -> S_A with err=0.
- Simultaneous events: enter and clear rise in the same cycle while in S_OP -> S_A, all registers zero. Enter and op_next together in S_OP -> S_B with op_sel unchanged.
- Clear and reset during S_CALC: clear, then alu_done 3 cycles later -> state S_A, result stays 0. Assert rst while in S_CALC -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and button indices for the calculator entry controller
package calc_pkg;

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_OP   = 3'd1,
      S_B    = 3'd2,
      S_CALC = 3'd3,
      S_SHOW = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } op_t;

   localparam int BTN_ENTER = 0;
   localparam int BTN_NEXT  = 1;
   localparam int BTN_PREV  = 2;
   localparam int BTN_CLEAR = 3;
   localparam int N_BTN     = 4;

endpackage

// File: rtl/btn_lockout.sv
// rtl/btn_lockout.sv - button synchroniser, rising-edge detect and hold-off lockout
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   raw      : asynchronous button level
//   evt      : one-cycle pulse for each accepted rising edge
module btn_lockout #(
   parameter int LOCKOUT_CYC = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic evt
);

   localparam int CW = $clog2(LOCKOUT_CYC + 1);
   localparam logic [CW-1:0] LOAD = CW'(LOCKOUT_CYC);

   logic          sync1;
   logic          sync2;
   logic          prev;
   logic [CW-1:0] cnt;
   logic          rise;

   assign rise = sync2 & ~prev;
   // Edges seen while the counter is running are bounce and are discarded.
   assign evt  = rise & (cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         prev  <= sync2;
         if (evt)
            cnt <= LOAD;
         else if (cnt != '0)
            cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/calc_entry_ctrl.sv
// rtl/calc_entry_ctrl.sv - operand/operator entry sequencer with ALU start/done handshake
// Ports:
//   clk, rst             : system clock, synchronous active-high reset
//   btn_raw[3:0]         : enter, op_next, op_prev, clear (raw levels)
//   sw[W-1:0]            : operand switches
//   alu_done, alu_result : ALU completion pulse and its result
//   op_a, op_b, op_sel   : latched operands and operator
//   alu_start            : one-cycle ALU request
//   result, result_valid : latched result, high while showing it
//   err                  : divide-by-zero flag while showing
//   state_o              : current state encoding
module calc_entry_ctrl
   import calc_pkg::*;
#(
   parameter int W           = 8,
   parameter int LOCKOUT_CYC = 1000000
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [3:0]     btn_raw,
   input  logic [W-1:0]   sw,
   input  logic           alu_done,
   input  logic [2*W-1:0] alu_result,
   output logic [W-1:0]   op_a,
   output logic [W-1:0]   op_b,
   output logic [1:0]     op_sel,
   output logic           alu_start,
   output logic [2*W-1:0] result,
   output logic           result_valid,
   output logic           err,
   output logic [2:0]     state_o
);

   logic [N_BTN-1:0] evt;

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_lockout #(.LOCKOUT_CYC(LOCKOUT_CYC)) u_btn (
         .clk (clk),
         .rst (rst),
         .raw (btn_raw[i]),
         .evt (evt[i])
      );
   end

   // Fixed priority clear > enter > op_next > op_prev; losers are simply dropped.
   logic ev_clear, ev_enter, ev_next, ev_prev;
   assign ev_clear = evt[BTN_CLEAR];
   assign ev_enter = evt[BTN_ENTER] & ~ev_clear;
   assign ev_next  = evt[BTN_NEXT]  & ~ev_clear & ~evt[BTN_ENTER];
   assign ev_prev  = evt[BTN_PREV]  & ~ev_clear & ~evt[BTN_ENTER] & ~evt[BTN_NEXT];

   state_t         state, state_n;
   op_t            sel, sel_n;
   logic [W-1:0]   a_n, b_n;
   logic [2*W-1:0] res_n;
   logic           err_n, start_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_A;
         op_a      <= '0;
         op_b      <= '0;
         sel       <= OP_ADD;
         result    <= '0;
         err       <= 1'b0;
         alu_start <= 1'b0;
      end else begin
         state     <= state_n;
         op_a      <= a_n;
         op_b      <= b_n;
         sel       <= sel_n;
         result    <= res_n;
         err       <= err_n;
         alu_start <= start_n;
      end
   end

   always_comb begin
      state_n = state;
      a_n     = op_a;
      b_n     = op_b;
      sel_n   = sel;
      res_n   = result;
      err_n   = err;
      start_n = 1'b0;
      if (ev_clear) begin
         // Leaving S_CALC here means any late alu_done lands outside S_CALC.
         state_n = S_A;
         a_n     = '0;
         b_n     = '0;
         sel_n   = OP_ADD;
         res_n   = '0;
         err_n   = 1'b0;
      end else begin
         case (state)
            S_A: begin
               if (ev_enter) begin
                  a_n     = sw;
                  state_n = S_OP;
               end
            end
            S_OP: begin
               if (ev_enter)
                  state_n = S_B;
               else if (ev_next)
                  sel_n = op_t'(sel + 2'd1);
               else if (ev_prev)
                  sel_n = op_t'(sel - 2'd1);
            end
            S_B: begin
               if (ev_enter) begin
                  b_n = sw;
                  if (sel == OP_DIV && sw == '0) begin
                     res_n   = '0;
                     err_n   = 1'b1;
                     state_n = S_SHOW;
                  end else begin
                     // Registered, so the pulse covers the first S_CALC cycle.
                     start_n = 1'b1;
                     state_n = S_CALC;
                  end
               end
            end
            S_CALC: begin
               if (alu_done) begin
                  res_n   = alu_result;
                  err_n   = 1'b0;
                  state_n = S_SHOW;
               end
            end
            S_SHOW: begin
               if (ev_enter) begin
                  err_n   = 1'b0;
                  state_n = S_A;
               end
            end
            default: state_n = S_A;
         endcase
      end
   end

   assign op_sel       = sel;
   assign result_valid = (state == S_SHOW);
   assign state_o      = state;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb/tb_calc_entry_ctrl.sv - self-checking scoreboard bench for calc_entry_ctrl
module tb_calc_entry_ctrl;

   localparam int W  = 8;
   localparam int LC = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [3:0]     btn = '0;
   logic [W-1:0]   sw = '0;
   logic           alu_done = 1'b0;
   logic [2*W-1:0] alu_result = '0;
   logic [W-1:0]   op_a, op_b;
   logic [1:0]     op_sel;
   logic           alu_start;
   logic [2*W-1:0] result;
   logic           result_valid;
   logic           err;
   logic [2:0]     state_o;

   calc_entry_ctrl #(.W(W), .LOCKOUT_CYC(LC)) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_raw      (btn),
      .sw           (sw),
      .alu_done     (alu_done),
      .alu_result   (alu_result),
      .op_a         (op_a),
      .op_b         (op_b),
      .op_sel       (op_sel),
      .alu_start    (alu_start),
      .result       (result),
      .result_valid (result_valid),
      .err          (err),
      .state_o      (state_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [1:0]     sel;
      logic [2*W-1:0] res;
      logic           e;
   } exp_t;

   exp_t sb[$];

   // Scoreboard: pop one expectation each time the DUT starts showing a result.
   logic rv_q = 1'b0;
   always @(negedge clk) begin
      if (result_valid && !rv_q) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_t x;
            x = sb.pop_front();
            check("sb_result", 32'(result), 32'(x.res));
            check("sb_err",    32'(err),    32'(x.e));
            check("sb_op_a",   32'(op_a),   32'(x.a));
            check("sb_op_b",   32'(op_b),   32'(x.b));
            check("sb_op_sel", 32'(op_sel), 32'(x.sel));
            check("sb_state",  32'(state_o), 32'd4);
         end
      end
      rv_q = result_valid;
   end

   int start_cnt = 0;
   always @(negedge clk) if (alu_start) start_cnt++;

   // ALU responder: answers each alu_start after alu_lat cycles.
   int alu_lat = 1;
   initial begin
      logic [2*W-1:0] r;
      forever begin
         @(negedge clk);
         if (alu_start) begin
            case (op_sel)
               2'd0: r = (2*W)'(op_a) + (2*W)'(op_b);
               2'd1: r = (2*W)'(op_a) - (2*W)'(op_b);
               2'd2: r = (2*W)'(op_a) * (2*W)'(op_b);
               default: r = (op_b == '0) ? '0 : (2*W)'(op_a / op_b);
            endcase
            repeat (alu_lat - 1) @(negedge clk);
            alu_result = r;
            alu_done   = 1'b1;
            @(negedge clk);
            alu_done   = 1'b0;
         end
      end
   end

   task automatic press(input logic [3:0] m);
      @(negedge clk);
      btn = m;
      @(negedge clk);
      btn = '0;
      repeat (7) @(negedge clk);
   endtask

   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s,
                       input logic [2*W-1:0] r, input logic e);
      exp_t x;
      x.a = a; x.b = b; x.sel = s; x.res = r; x.e = e;
      sb.push_back(x);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_state",  32'(state_o), 32'd0);
      check("rst_op_a",   32'(op_a), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_start",  32'(alu_start), 32'd0);
      check("rst_rv",     32'(result_valid), 32'd0);

      // Full ADD flow
      sw = 8'd5; press(4'b0001);
      check("add_sa_state", 32'(state_o), 32'd1);
      check("add_op_a",     32'(op_a), 32'd5);
      press(4'b0001);
      check("add_sop_state", 32'(state_o), 32'd2);
      sw = 8'd7;
      push(8'd5, 8'd7, 2'd0, 16'd12, 1'b0);
      press(4'b0001);
      check("add_start_cnt", 32'(start_cnt), 32'd1);
      check("add_rv",        32'(result_valid), 32'd1);
      press(4'b0001);
      check("show_exit_state", 32'(state_o), 32'd0);
      check("show_exit_rv",    32'(result_valid), 32'd0);
      check("show_keep_op_a",  32'(op_a), 32'd5);

      // Lockout: long hold gives one event
      sw = 8'd3;
      @(negedge clk); btn = 4'b0001;
      repeat (10) @(negedge clk);
      btn = '0;
      repeat (7) @(negedge clk);
      check("hold_one_event", 32'(state_o), 32'd1);
      // Two rises 2 cycles apart: second is bounce
      btn = 4'b0001; @(negedge clk); btn = '0; @(negedge clk);
      btn = 4'b0001; @(negedge clk); btn = '0;
      repeat (8) @(negedge clk);
      check("bounce_2cyc", 32'(state_o), 32'd2);
      press(4'b1000);
      check("clear_op_a", 32'(op_a), 32'd0);
      // Two rises 6 cycles apart: both count
      btn = 4'b0001; @(negedge clk); btn = '0;
      repeat (5) @(negedge clk);
      btn = 4'b0001; @(negedge clk); btn = '0;
      repeat (8) @(negedge clk);
      check("rises_6cyc", 32'(state_o), 32'd2);

      // Operator wrap and divide-by-zero
      press(4'b1000);
      sw = 8'd9; press(4'b0001);
      press(4'b0100);
      check("wrap_prev", 32'(op_sel), 32'd3);
      press(4'b0010);
      check("wrap_next", 32'(op_sel), 32'd0);
      press(4'b0100);
      press(4'b0001);
      sw = 8'd0;
      push(8'd9, 8'd0, 2'd3, 16'd0, 1'b1);
      press(4'b0001);
      check("div0_no_start", 32'(start_cnt), 32'd1);
      check("div0_err",      32'(err), 32'd1);
      press(4'b0001);
      check("div0_exit_state", 32'(state_o), 32'd0);
      check("div0_exit_err",   32'(err), 32'd0);

      // Simultaneous events
      sw = 8'd4; press(4'b0001);
      press(4'b1001);
      check("sim_clr_state", 32'(state_o), 32'd0);
      check("sim_clr_op_a",  32'(op_a), 32'd0);
      check("sim_clr_sel",   32'(op_sel), 32'd0);
      press(4'b0001);
      press(4'b0010);
      press(4'b0011);
      check("sim_ent_state", 32'(state_o), 32'd2);
      check("sim_ent_sel",   32'(op_sel), 32'd1);

      // Clear during S_CALC, late alu_done ignored
      alu_lat = 12;
      sw = 8'd2; press(4'b0001);
      check("calc_state", 32'(state_o), 32'd3);
      check("calc_start_cnt", 32'(start_cnt), 32'd2);
      press(4'b1000);
      repeat (10) @(negedge clk);
      check("calc_clr_state",  32'(state_o), 32'd0);
      check("calc_clr_result", 32'(result), 32'd0);
      check("calc_clr_op_b",   32'(op_b), 32'd0);

      // Reset during S_CALC
      sw = 8'd6; press(4'b0001);
      press(4'b0001);
      sw = 8'd3; press(4'b0001);
      check("calc2_state", 32'(state_o), 32'd3);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      check("rst2_state",  32'(state_o), 32'd0);
      check("rst2_op_a",   32'(op_a), 32'd0);
      check("rst2_op_b",   32'(op_b), 32'd0);
      check("rst2_sel",    32'(op_sel), 32'd0);
      check("rst2_result", 32'(result), 32'd0);
      check("rst2_start",  32'(alu_start), 32'd0);
      check("rst2_rv",     32'(result_valid), 32'd0);
      check("rst2_err",    32'(err), 32'd0);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      check("rst2_late_done_state",  32'(state_o), 32'd0);
      check("rst2_late_done_result", 32'(result), 32'd0);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
